queue_sensor_front: RTL

Front-end conditioner for the queue-management people counter. It takes the two raw photo-sensor lines at the queue entry and at the teller exit, then synchronises and debounces them. It turns each clean rising edge into a single-cycle step strobe with a direction bit, which the downstream up/down counter consumes. It also flags sensors stuck blocked and reports simultaneous entry/exit events, which cancel.

---
 rtl/qm_pkg.sv | 23 ++
 rtl/queue_sensor_front_if.sv | 23 ++
 rtl/sensor_debounce.sv | 82 ++++++++
 rtl/queue_sensor_front.sv | 81 ++++++++
 4 files changed

// File: rtl/qm_pkg.sv
// Shared definitions for the queue-management people counter:
// direction encoding, default timing parameters and counter sizing.
package qm_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int DEB_CYCLES_DEF   = 16;
    localparam int STUCK_CYCLES_DEF = 1024;

    // Bits needed to hold every value 0..max_count without wrapping.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_UP,
        ARB_DOWN,
        ARB_CANCEL
    } arb_e;

endpackage

// File: rtl/queue_sensor_front_if.sv
// Sensor-side bundle of the queue front end: raw beam lines in,
// step/direction/cancel strobes and fault flags out.
interface queue_sensor_front_if;

    logic entry_raw;
    logic exit_raw;
    logic step;
    logic switch;
    logic cancel;
    logic entry_fault;
    logic exit_fault;

    modport master (
        output entry_raw, exit_raw,
        input  step, switch, cancel, entry_fault, exit_fault
    );

    modport slave (
        input  entry_raw, exit_raw,
        output step, switch, cancel, entry_fault, exit_fault
    );

endinterface

// File: rtl/sensor_debounce.sv
// One photo-sensor conditioning chain: two-flop synchroniser, debouncer,
// rising-edge event detector and stuck-blocked detector.
module sensor_debounce
    import qm_pkg::*;
#(
    parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
    parameter int STUCK_CYCLES = STUCK_CYCLES_DEF
) (
    input  logic clkup,
    input  logic reset,
    input  logic raw,
    output logic evt,
    output logic fault
);

    localparam int DW = cnt_width(DEB_CYCLES);
    localparam int SW = cnt_width(STUCK_CYCLES);
    localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CYCLES);
    localparam logic [SW-1:0] STUCK_MAX = SW'(STUCK_CYCLES);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          level_prev_q, level_prev_d;
    logic          fault_q, fault_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [SW-1:0] stuck_cnt_q, stuck_cnt_d;

    // NOTE: every next-state variable gets a default at the top of the block,
    // so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        sync1_d      = raw;
        sync2_d      = sync1_q;
        level_d      = level_q;
        deb_cnt_d    = '0;
        level_prev_d = level_q;
        stuck_cnt_d  = '0;

        // The flip happens on the sample after the counter has reached the
        // limit, so the new level needs DEB_CYCLES+1 disagreeing samples.
        if (sync2_q != level_q) begin
            if (deb_cnt_q == DEB_MAX) begin
                level_d = ~level_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DW'(1);
            end
        end

        if (level_q) begin
            stuck_cnt_d = (stuck_cnt_q == STUCK_MAX) ? stuck_cnt_q : stuck_cnt_q + SW'(1);
        end

        fault_d = (stuck_cnt_d == STUCK_MAX);
    end

    // NOTE: state is updated only with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clkup) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            fault_q      <= 1'b0;
            deb_cnt_q    <= '0;
            stuck_cnt_q  <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            level_q      <= level_d;
            level_prev_q <= level_prev_d;
            fault_q      <= fault_d;
            deb_cnt_q    <= deb_cnt_d;
            stuck_cnt_q  <= stuck_cnt_d;
        end
    end

    // Both sources are flops, so no raw input reaches these outputs directly.
    assign evt   = level_q & ~level_prev_q;
    assign fault = fault_q;

endmodule

// File: rtl/queue_sensor_front.sv
// Queue entry/exit front end: two conditioned sensors feeding a registered
// arbiter that emits up/down step strobes or a cancel when events coincide.
module queue_sensor_front
    import qm_pkg::*;
#(
    parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
    parameter int STUCK_CYCLES = STUCK_CYCLES_DEF
) (
    input  logic                 clkup,
    input  logic                 reset,
    queue_sensor_front_if.slave  bus
);

    logic entry_evt;
    logic exit_evt;
    arb_e decision;

    logic step_q, step_d;
    logic switch_q, switch_d;
    logic cancel_q, cancel_d;

    sensor_debounce #(
        .DEB_CYCLES   (DEB_CYCLES),
        .STUCK_CYCLES (STUCK_CYCLES)
    ) u_entry (
        .clkup (clkup),
        .reset (reset),
        .raw   (bus.entry_raw),
        .evt   (entry_evt),
        .fault (bus.entry_fault)
    );

    sensor_debounce #(
        .DEB_CYCLES   (DEB_CYCLES),
        .STUCK_CYCLES (STUCK_CYCLES)
    ) u_exit (
        .clkup (clkup),
        .reset (reset),
        .raw   (bus.exit_raw),
        .evt   (exit_evt),
        .fault (bus.exit_fault)
    );

    always_comb begin
        unique case ({entry_evt, exit_evt})
            2'b10:   decision = ARB_UP;
            2'b01:   decision = ARB_DOWN;
            2'b11:   decision = ARB_CANCEL;
            default: decision = ARB_IDLE;
        endcase
    end

    // Direction is sticky: it only moves when a real step is issued.
    always_comb begin
        step_d   = (decision == ARB_UP) || (decision == ARB_DOWN);
        cancel_d = (decision == ARB_CANCEL);
        switch_d = switch_q;
        if (decision == ARB_UP) begin
            switch_d = DIR_UP;
        end else if (decision == ARB_DOWN) begin
            switch_d = DIR_DOWN;
        end
    end

    always_ff @(posedge clkup) begin
        if (reset) begin
            step_q   <= 1'b0;
            cancel_q <= 1'b0;
            switch_q <= DIR_UP;
        end else begin
            step_q   <= step_d;
            cancel_q <= cancel_d;
            switch_q <= switch_d;
        end
    end

    assign bus.step   = step_q;
    assign bus.cancel = cancel_q;
    assign bus.switch = switch_q;

endmodule
